// File: rtl/match_controller_pkg.sv
// Shared definitions for the match controller and the gameplay controllers it drives.
//   - match phase encodings (match_phase output)
//   - stunmode codes reported by hit detection
//   - winner codes
//   - gameplay-controller player-state encodings
//   - per-player scoreboard payload and the hit edge detector
package match_controller_pkg;

  localparam int unsigned PHASE_W   = 3;
  localparam int unsigned HEALTH_W  = 3;
  localparam int unsigned ROUNDS_W  = 2;
  localparam int unsigned SECONDS_W = 7;
  localparam int unsigned STUN_W    = 2;
  localparam int unsigned WINNER_W  = 2;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE      = 3'd0,
    PH_COUNTDOWN = 3'd1,
    PH_FIGHT     = 3'd2,
    PH_ROUND_END = 3'd3,
    PH_MATCH_END = 3'd4
  } phase_e;

  typedef enum logic [STUN_W-1:0] {
    STUN_NONE  = 2'b00,
    STUN_HIT   = 2'b01,
    STUN_BLOCK = 2'b10
  } stun_e;

  typedef enum logic [WINNER_W-1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  typedef enum logic [2:0] {
    PS_IDLE   = 3'd0,
    PS_WALK   = 3'd1,
    PS_ATTACK = 3'd2,
    PS_BLOCK  = 3'd3,
    PS_STUN   = 3'd4,
    PS_KO     = 3'd5
  } player_state_e;

  // Per-player scoreboard plus last-cycle stunmode for hit edge detection.
  typedef struct packed {
    logic [HEALTH_W-1:0] health;
    logic [ROUNDS_W-1:0] rounds;
    logic [STUN_W-1:0]   stun_prev;
  } player_t;

  // A hit counts once, on the cycle stunmode enters HIT from any other code.
  function automatic logic hit_edge(input logic [STUN_W-1:0] prev,
                                    input logic [STUN_W-1:0] cur);
    return (cur == STUN_HIT) && (prev != STUN_HIT);
  endfunction

endpackage

// File: rtl/match_controller_second_ticker.sv
// Frame counter that pulses once per second of frames.
//   clk        frame clock
//   rst_n      async active-low reset
//   clr        synchronous clear (phase change)
//   en         count enable; counter held at zero when low
//   sec_tick_c combinational pulse on the last frame of each second
module second_ticker #(
  parameter int unsigned FRAMES_PER_SEC = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic sec_tick_c
);

  localparam int unsigned CNT_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick must not depend on clr: clr is derived from the next phase, which uses the tick.
  assign sec_tick_c = en && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    if (en && !clr && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/match_controller.sv
// Match flow controller for a two-player fighting game.
//   logic_clk            frame clock (FRAMES_PER_SEC ticks per second)
//   reset_n              async active-low reset
//   start                start key level, edge-detected here
//   p1/p2_stunmode       hit detection per player: 00 none, 01 hit, 10 block
//   player_reset         holds both gameplay controllers except during FIGHT
//   match_phase          current phase
//   p1/p2_health         remaining health
//   p1/p2_rounds         rounds won
//   seconds_left         countdown or round seconds remaining
//   winner               00 none, 01 P1, 10 P2, 11 draw
module match_controller
  import match_controller_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC    = 60,
  parameter int unsigned ROUND_SECONDS     = 60,
  parameter int unsigned COUNTDOWN_SECONDS = 3,
  parameter int unsigned MAX_HEALTH        = 5,
  parameter int unsigned ROUNDS_TO_WIN     = 2,
  parameter int unsigned RESULT_FRAMES     = 120
) (
  input  logic                 logic_clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [STUN_W-1:0]    p1_stunmode,
  input  logic [STUN_W-1:0]    p2_stunmode,
  output logic                 player_reset,
  output logic [PHASE_W-1:0]   match_phase,
  output logic [HEALTH_W-1:0]  p1_health,
  output logic [HEALTH_W-1:0]  p2_health,
  output logic [ROUNDS_W-1:0]  p1_rounds,
  output logic [ROUNDS_W-1:0]  p2_rounds,
  output logic [SECONDS_W-1:0] seconds_left,
  output logic [WINNER_W-1:0]  winner
);

  localparam int unsigned RES_W = (RESULT_FRAMES > 1) ? $clog2(RESULT_FRAMES) : 1;
  localparam logic [RES_W-1:0]     RES_LAST   = RES_W'(RESULT_FRAMES - 1);
  localparam logic [HEALTH_W-1:0]  HEALTH_MAX = HEALTH_W'(MAX_HEALTH);
  localparam logic [ROUNDS_W-1:0]  ROUNDS_WIN = ROUNDS_W'(ROUNDS_TO_WIN);
  localparam logic [SECONDS_W-1:0] SEC_CD     = SECONDS_W'(COUNTDOWN_SECONDS);
  localparam logic [SECONDS_W-1:0] SEC_ROUND  = SECONDS_W'(ROUND_SECONDS);
  localparam player_t PLAYER_RST = '{health: HEALTH_MAX, rounds: '0, stun_prev: '0};

  phase_e               phase_q, phase_d;
  player_t              p1_q, p1_d, p2_q, p2_d;
  logic [SECONDS_W-1:0] seconds_q, seconds_d;
  logic [WINNER_W-1:0]  winner_q, winner_d;
  logic [RES_W-1:0]     res_cnt_q, res_cnt_d;
  logic                 start_q;
  logic                 player_reset_q, player_reset_d;

  logic start_edge;
  logic p1_hit, p2_hit;
  logic sec_tick_c;
  logic ticker_en;
  logic ticker_clr;

  assign start_edge = start && !start_q;
  assign p1_hit     = hit_edge(p1_q.stun_prev, p1_stunmode);
  assign p2_hit     = hit_edge(p2_q.stun_prev, p2_stunmode);
  assign ticker_en  = (phase_q == PH_COUNTDOWN) || (phase_q == PH_FIGHT);
  assign ticker_clr = (phase_d != phase_q);

  second_ticker #(
    .FRAMES_PER_SEC (FRAMES_PER_SEC)
  ) u_second_ticker (
    .clk        (logic_clk),
    .rst_n      (reset_n),
    .clr        (ticker_clr),
    .en         (ticker_en),
    .sec_tick_c (sec_tick_c)
  );

  // Next-state and scoreboard update.
  always_comb begin
    phase_d           = phase_q;
    p1_d              = p1_q;
    p2_d              = p2_q;
    seconds_d         = seconds_q;
    winner_d          = winner_q;
    res_cnt_d         = '0;
    p1_d.stun_prev    = p1_stunmode;
    p2_d.stun_prev    = p2_stunmode;

    case (phase_q)
      PH_IDLE: begin
        if (start_edge) begin
          phase_d     = PH_COUNTDOWN;
          p1_d.rounds = '0;
          p2_d.rounds = '0;
          p1_d.health = HEALTH_MAX;
          p2_d.health = HEALTH_MAX;
          seconds_d   = SEC_CD;
          winner_d    = WIN_NONE;
        end
      end

      PH_COUNTDOWN: begin
        if (sec_tick_c) begin
          if (seconds_q <= SECONDS_W'(1)) begin
            phase_d   = PH_FIGHT;
            seconds_d = SEC_ROUND;
          end else begin
            seconds_d = seconds_q - SECONDS_W'(1);
          end
        end
      end

      PH_FIGHT: begin
        // The exit cycle freezes the scoreboard so the displayed health matches the decision.
        if ((p1_q.health == '0) || (p2_q.health == '0) || (seconds_q == '0)) begin
          phase_d = PH_ROUND_END;
          if (p1_q.health > p2_q.health) begin
            p1_d.rounds = p1_q.rounds + ROUNDS_W'(1);
            winner_d    = WIN_P1;
          end else if (p2_q.health > p1_q.health) begin
            p2_d.rounds = p2_q.rounds + ROUNDS_W'(1);
            winner_d    = WIN_P2;
          end else begin
            winner_d    = WIN_DRAW;
          end
        end else begin
          // All counters are non-zero here, so plain decrements already saturate at 0.
          if (sec_tick_c) seconds_d = seconds_q - SECONDS_W'(1);
          if (p1_hit) p1_d.health = p1_q.health - HEALTH_W'(1);
          if (p2_hit) p2_d.health = p2_q.health - HEALTH_W'(1);
        end
      end

      PH_ROUND_END: begin
        if (res_cnt_q == RES_LAST) begin
          if ((p1_q.rounds == ROUNDS_WIN) || (p2_q.rounds == ROUNDS_WIN)) begin
            phase_d  = PH_MATCH_END;
            winner_d = (p1_q.rounds == ROUNDS_WIN) ? WIN_P1 : WIN_P2;
          end else begin
            phase_d     = PH_COUNTDOWN;
            p1_d.health = HEALTH_MAX;
            p2_d.health = HEALTH_MAX;
            seconds_d   = SEC_CD;
            winner_d    = WIN_NONE;
          end
        end else begin
          res_cnt_d = res_cnt_q + RES_W'(1);
        end
      end

      PH_MATCH_END: begin
        if (start_edge) phase_d = PH_IDLE;
      end

      default: phase_d = PH_IDLE;
    endcase

    player_reset_d = (phase_d != PH_FIGHT);
  end

  always_ff @(posedge logic_clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q        <= PH_IDLE;
      p1_q           <= PLAYER_RST;
      p2_q           <= PLAYER_RST;
      seconds_q      <= '0;
      winner_q       <= WIN_NONE;
      res_cnt_q      <= '0;
      start_q        <= 1'b0;
      player_reset_q <= 1'b1;
    end else begin
      phase_q        <= phase_d;
      p1_q           <= p1_d;
      p2_q           <= p2_d;
      seconds_q      <= seconds_d;
      winner_q       <= winner_d;
      res_cnt_q      <= res_cnt_d;
      start_q        <= start;
      player_reset_q <= player_reset_d;
    end
  end

  assign player_reset = player_reset_q;
  assign match_phase  = phase_q;
  assign p1_health    = p1_q.health;
  assign p2_health    = p2_q.health;
  assign p1_rounds    = p1_q.rounds;
  assign p2_rounds    = p2_q.rounds;
  assign seconds_left = seconds_q;
  assign winner       = winner_q;

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameters SHALL be: FRAMES_PER_SEC, default 60, logic_clk ticks per second; ROUND_SECONDS, default 60, round time limit; COUNTDOWN_SECONDS, default 3, pre-fight countdown; MAX_HEALTH, default 5, hits to KO; ROUNDS_TO_WIN, default 2; RESULT_FRAMES, default 120, ROUND_END hold time.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low. Port logic_clk is input, 1 bit, the 60 Hz frame clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  level from the start key; edge-detected internally.
REQ-005 p1_stunmode, p2_stunmode  input  2 each  hit-detection result per player: 00 none, 01 hit, 10 block.
REQ-006 player_reset  output  1  active-high hold/reset to both gameplay controllers.
REQ-007 match_phase  output  3  current FSM state.
REQ-008 p1_health, p2_health  output  3 each  remaining health.
REQ-009 p1_rounds, p2_rounds  output  2 each  rounds won.
REQ-010 seconds_left  output  7  countdown or round seconds remaining.
REQ-011 winner  output  2  00 none, 01 P1, 10 P2, 11 draw (last round).

Function
REQ-012 FSM states SHALL be IDLE, COUNTDOWN, FIGHT, ROUND_END, MATCH_END.
REQ-013 start_edge SHALL be start high this cycle and low the previous cycle.
REQ-014 IDLE: on start_edge the FSM SHALL go to COUNTDOWN next edge and load rounds=0, health=MAX_HEALTH, seconds_left=COUNTDOWN_SECONDS, winner=00.
REQ-015 A frame counter SHALL count 0..FRAMES_PER_SEC-1 in COUNTDOWN and FIGHT, clear on every state change, and pulse sec_tick on wrap.
REQ-016 COUNTDOWN: each sec_tick SHALL decrement seconds_left. The tick that would take it to 0 SHALL instead enter FIGHT with seconds_left=ROUND_SECONDS.
REQ-017 FIGHT: each sec_tick SHALL decrement seconds_left, saturating at 0.
REQ-018 FIGHT: a transition of pX_stunmode into 01 from any other value SHALL decrement pX_health by 1, saturating at 0.
REQ-019 Stunmode 10 (block) SHALL do no damage. A stunmode held at 01 SHALL count as one hit only.
REQ-020 If both players are hit in the same cycle, both health values SHALL decrement on the same edge.
REQ-021 Stunmode SHALL be ignored outside FIGHT.
REQ-022 FIGHT SHALL exit to ROUND_END on the edge after registered health of either player is 0 or seconds_left is 0. The exit cycle SHALL evaluate the registered values of that cycle, so a hit and a timeout on the same edge are both counted.
REQ-023 On ROUND_END entry, the round winner SHALL be the player with higher health. That player's rounds SHALL increment and winner SHALL be set. Equal health SHALL set winner=11 with no round awarded.
REQ-024 ROUND_END SHALL last RESULT_FRAMES cycles. It SHALL then go to MATCH_END if either rounds equals ROUNDS_TO_WIN; otherwise it SHALL go to COUNTDOWN, reloading health and seconds_left.
REQ-025 MATCH_END SHALL hold winner at the match winner. On start_edge it SHALL go to IDLE, keeping the score visible.
REQ-026 start_edge SHALL be ignored in COUNTDOWN, FIGHT and ROUND_END.
REQ-027 player_reset SHALL be 0 only in FIGHT and 1 in all other states.

Reset
REQ-028 While reset_n is low, the block SHALL set match_phase=IDLE, player_reset=1, health=MAX_HEALTH, rounds=0, seconds_left=0, winner=00, and clear the frame counter and edge registers. This SHALL apply immediately and asynchronously, including mid-round.

Structure
REQ-029 The shared package SHALL hold the match_phase encodings, the stunmode codes (NONE/HIT/BLOCK), the winner codes, and the gameplay-controller player-state encodings.
REQ-030 The frame-counter/sec_tick generator SHALL be one sub-module, second_ticker, with a synchronous clear.

Verification
REQ-031 Release reset, pulse start -> COUNTDOWN at 3, then FIGHT after exactly 180 cycles with seconds_left=60 and player_reset=0.
REQ-032 In FIGHT, hold p2_stunmode=01 for 10 cycles, then 00, then 01 -> p2_health goes 5->4->3 and p1_health is unchanged. Then p2_stunmode=10 -> no change.
REQ-033 Both stunmodes go 00->01 on the same cycle -> both health values reach 4 on the same edge.
REQ-034 Five P2 hits -> p2_health=0, then next edge ROUND_END with winner=01 and p1_rounds=1. After 120 cycles, COUNTDOWN with health reloaded to 5.
REQ-035 Timeout at equal health -> winner=11 with no round awarded. Next, P1 wins two rounds -> MATCH_END with winner=01, and start -> IDLE.
REQ-036 Assert reset_n low mid-FIGHT between edges -> outputs reach reset values immediately and start is required again.
